// File: rtl/irq_onehot_arbiter_16.sv
// rtl/irq_onehot_arbiter_16.sv - 16-line request capture with round-robin one-hot grant and valid/ready hold
// Optional line masking is compiled in with `define IRQ_MASK_EN.
module irq_onehot_arbiter_16 #(
  parameter int EDGE_CAPTURE = 1,
  parameter int PTR_RST      = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        grant_rdy,
`ifdef IRQ_MASK_EN
  input  logic [15:0] mask,
`endif
  output logic [15:0] grant_oh,
  output logic        grant_vld,
  output logic [15:0] pending,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] req_q;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] grant_oh_q, grant_oh_d;
  logic        grant_vld_q, grant_vld_d;
  logic [3:0]  gnt_idx_q, gnt_idx_d;

  logic [15:0] mask_n;
  logic [15:0] set_vec;
  logic [15:0] clr_vec;
  logic [15:0] eligible;
  logic        accept;
  logic        more;
  logic        found;
  logic [3:0]  sel_idx;
  logic [3:0]  cand;

`ifdef IRQ_MASK_EN
  assign mask_n = ~mask;
`else
  assign mask_n = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      pending_q   <= '0;
      ptr_q       <= 4'(PTR_RST);
      grant_oh_q  <= '0;
      grant_vld_q <= 1'b0;
      gnt_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      grant_oh_q  <= grant_oh_d;
      grant_vld_q <= grant_vld_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  // Capture: a set arriving on the bit being cleared this cycle wins.
  always_comb begin
    set_vec   = (EDGE_CAPTURE != 0) ? (req & ~req_q) : req;
    set_vec   = set_vec & mask_n;
    accept    = (state_q == HOLD) && grant_vld_q && grant_rdy;
    clr_vec   = accept ? grant_oh_q : '0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    eligible  = pending_q & mask_n;
    more      = |(((pending_q & ~grant_oh_q) | set_vec) & mask_n);
  end

  // Circular first-set search from ptr; descending scan so the nearest hit is written last.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int i = 15; i >= 0; i--) begin
      cand = ptr_q + 4'(i);
      if (eligible[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|eligible) state_d = ARB;
      ARB:     state_d = found ? HOLD : IDLE;
      HOLD:    if (accept) state_d = more ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_oh_d  = grant_oh_q;
    grant_vld_d = grant_vld_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    case (state_q)
      ARB: begin
        if (found) begin
          grant_oh_d  = 16'b1 << sel_idx;
          grant_vld_d = 1'b1;
          gnt_idx_d   = sel_idx;
        end
      end
      HOLD: begin
        if (accept) begin
          grant_oh_d  = '0;
          grant_vld_d = 1'b0;
          ptr_d       = gnt_idx_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  assign grant_oh  = grant_oh_q;
  assign grant_vld = grant_vld_q;
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE) || (|eligible);

endmodule

// File: tb/tb_irq_onehot_arbiter_16.sv
// tb/tb_irq_onehot_arbiter_16.sv - directed bench for irq_onehot_arbiter_16 (edge and level instances)
`timescale 1ns/1ps
module tb_irq_onehot_arbiter_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req, req2;
  logic        rdy, rdy2;
  logic [15:0] mask;
  logic [15:0] g_oh, l_oh;
  logic        g_vld, l_vld;
  logic [15:0] pend, l_pend;
  logic        busy, l_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_onehot_arbiter_16 #(.EDGE_CAPTURE(1), .PTR_RST(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant_rdy (rdy),
`ifdef IRQ_MASK_EN
    .mask      (mask),
`endif
    .grant_oh  (g_oh),
    .grant_vld (g_vld),
    .pending   (pend),
    .busy      (busy)
  );

  irq_onehot_arbiter_16 #(.EDGE_CAPTURE(0), .PTR_RST(0)) u_lvl (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req2),
    .grant_rdy (rdy2),
`ifdef IRQ_MASK_EN
    .mask      (16'h0000),
`endif
    .grant_oh  (l_oh),
    .grant_vld (l_vld),
    .pending   (l_pend),
    .busy      (l_busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot_edge", {15'd0, $onehot0(g_oh)}, 16'h0001);
      chk("onehot_lvl",  {15'd0, $onehot0(l_oh)}, 16'h0001);
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; req2 = '0; rdy = 1'b0; rdy2 = 1'b0; mask = '0;
    #1;
    chk("rst_oh",   g_oh, 16'h0000);
    chk("rst_vld",  {15'd0, g_vld}, 16'h0000);
    chk("rst_pend", pend, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    step; step;
    rst_n = 1'b1;
    step;

    // all lines rise together, rdy high: grants 0..15, one every two cycles
    req = 16'hffff; rdy = 1'b1;
    step;
    chk("all_pend", pend, 16'hffff);
    chk("all_vld0", {15'd0, g_vld}, 16'h0000);
    step;
    chk("all_busy", {15'd0, busy}, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      step;
      chk($sformatf("all_gnt%0d", i), g_oh, 16'h0001 << i);
      chk($sformatf("all_vld%0d", i), {15'd0, g_vld}, 16'h0001);
      step;
      chk($sformatf("all_drop%0d", i), {15'd0, g_vld}, 16'h0000);
    end
    chk("all_end_pend", pend, 16'h0000);
    chk("all_end_busy", {15'd0, busy}, 16'h0000);
    req = '0; rdy = 1'b0;
    step;

    // single event on line 5, held five cycles
    req = 16'h0020;
    step;
    req = '0;
    chk("se_pend", pend, 16'h0020);
    chk("se_vld_e0", {15'd0, g_vld}, 16'h0000);
    step;
    chk("se_vld_e1", {15'd0, g_vld}, 16'h0000);
    step;
    chk("se_gnt", g_oh, 16'h0020);
    chk("se_vld", {15'd0, g_vld}, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("se_hold%0d", i), g_oh, 16'h0020);
      chk($sformatf("se_holdv%0d", i), {15'd0, g_vld}, 16'h0001);
    end
    rdy = 1'b1;
    step;
    rdy = 1'b0;
    chk("se_acc_vld",  {15'd0, g_vld}, 16'h0000);
    chk("se_acc_oh",   g_oh, 16'h0000);
    chk("se_acc_pend", pend, 16'h0000);
    chk("se_acc_busy", {15'd0, busy}, 16'h0000);

    // line 3 once to move ptr to 4
    req = 16'h0008;
    step; req = '0;
    step; step;
    chk("fr_pre_gnt", g_oh, 16'h0008);
    rdy = 1'b1; step; rdy = 1'b0;
    chk("fr_pre_idle", {15'd0, busy}, 16'h0000);

    // fairness: {3,7} from ptr 4 -> 7 then 3, with 3 re-rising on its accept
    req = 16'h0088;
    step; req = '0;
    chk("fr_pend", pend, 16'h0088);
    step; step;
    chk("fr_gnt7", g_oh, 16'h0080);
    rdy = 1'b1;
    step;
    chk("fr_acc7", {15'd0, g_vld}, 16'h0000);
    chk("fr_pend3", pend, 16'h0008);
    step;
    chk("fr_gnt3", g_oh, 16'h0008);
    req = 16'h0008;
    step;
    req = '0;
    chk("fr_repend", pend, 16'h0008);
    chk("fr_acc3_vld", {15'd0, g_vld}, 16'h0000);
    step;
    chk("fr_regnt3", g_oh, 16'h0008);
    step;
    rdy = 1'b0;
    chk("fr_end_pend", pend, 16'h0000);
    chk("fr_end_busy", {15'd0, busy}, 16'h0000);

    // async reset in HOLD with line 15 granted; ptr is 4 before reset
    req = 16'h8000;
    step; req = '0;
    step; step;
    chk("rs_gnt15", g_oh, 16'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_oh",   g_oh, 16'h0000);
    chk("rs_vld",  {15'd0, g_vld}, 16'h0000);
    chk("rs_pend", pend, 16'h0000);
    chk("rs_busy", {15'd0, busy}, 16'h0000);
    @(negedge clk) rst_n = 1'b1;
    step;
    req = 16'h4002;
    step; req = '0;
    step; step;
    chk("rs_first", g_oh, 16'h0002);
    rdy = 1'b1;
    step; step;
    chk("rs_second", g_oh, 16'h4000);
    step;
    rdy = 1'b0;
    chk("rs_end_pend", pend, 16'h0000);

    // level mode: line 9 held high is re-granted after every accept
    req2 = 16'h0200; rdy2 = 1'b1;
    step;
    chk("lv_pend", l_pend, 16'h0200);
    step;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("lv_gnt%0d", i), l_oh, 16'h0200);
      step;
      chk($sformatf("lv_acc%0d", i), {15'd0, l_vld}, 16'h0000);
      chk($sformatf("lv_pend%0d", i), l_pend, 16'h0200);
    end
    step;
    chk("lv_last_gnt", l_oh, 16'h0200);
    req2 = '0;
    step;
    chk("lv_stop_vld",  {15'd0, l_vld}, 16'h0000);
    chk("lv_stop_pend", l_pend, 16'h0000);
    chk("lv_stop_busy", {15'd0, l_busy}, 16'h0000);
    step; step;
    chk("lv_quiet", {15'd0, l_vld}, 16'h0000);
    rdy2 = 1'b0;

`ifdef IRQ_MASK_EN
    // masked line 2 rises while masked: never captured, so no grant after unmask
    mask = 16'h0004;
    req = 16'h0404;
    step; req = '0;
    chk("mk_pend", pend, 16'h0400);
    step; step;
    chk("mk_gnt10", g_oh, 16'h0400);
    rdy = 1'b1; step; rdy = 1'b0;
    mask = '0;
    step; step; step;
    chk("mk_nognt", {15'd0, g_vld}, 16'h0000);
    chk("mk_busy",  {15'd0, busy}, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
